perf_counter: RTL and testbench

//  Performance-counter unit that consumes the special control signals produced by instruction

---
 rtl/perf_counter.sv | 97 +++++++++
 tb/tb_perf_counter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter.sv
// Cycle and retired-instruction performance counters, each with a STOP/RUN FSM,
// driven by decode control events and read through a registered port.
module perf_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             evt_valid,
   input  logic             str_ccnt,
   input  logic             str_icnt,
   input  logic             stp_cnt,
   input  logic             inc_instr,
   input  logic             rd_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic             ccnt_run,
   output logic             icnt_run,
   output logic             ccnt_ovf,
   output logic             icnt_ovf
);

   typedef enum logic [0:0] {StStop, StRun} run_e;

   run_e             ccnt_st_q, ccnt_st_d;
   run_e             icnt_st_q, icnt_st_d;
   logic [WIDTH-1:0] ccnt_q, ccnt_d;
   logic [WIDTH-1:0] icnt_q, icnt_d;
   logic             ccnt_ovf_q, ccnt_ovf_d;
   logic             icnt_ovf_q, icnt_ovf_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;

   logic evt_stp, evt_strc, evt_stri, evt_inc;

   always_comb begin
      evt_stp  = evt_valid & stp_cnt;
      evt_strc = evt_valid & str_ccnt;
      evt_stri = evt_valid & str_icnt;
      evt_inc  = evt_valid & inc_instr;

      ccnt_st_d  = ccnt_st_q;
      ccnt_d     = ccnt_q;
      ccnt_ovf_d = ccnt_ovf_q;
      // Stop wins over start and increment; the cycle counter also ticks on stalled cycles.
      if (evt_stp) begin
         ccnt_st_d = StStop;
      end else if (evt_strc) begin
         ccnt_st_d  = StRun;
         ccnt_d     = '0;
         ccnt_ovf_d = 1'b0;
      end else if (ccnt_st_q == StRun) begin
         ccnt_d = ccnt_q + WIDTH'(1);
         if (&ccnt_q) ccnt_ovf_d = 1'b1;
      end

      icnt_st_d  = icnt_st_q;
      icnt_d     = icnt_q;
      icnt_ovf_d = icnt_ovf_q;
      if (evt_stp) begin
         icnt_st_d = StStop;
      end else if (evt_stri) begin
         icnt_st_d  = StRun;
         icnt_d     = '0;
         icnt_ovf_d = 1'b0;
      end else if (icnt_st_q == StRun && evt_inc) begin
         icnt_d = icnt_q + WIDTH'(1);
         if (&icnt_q) icnt_ovf_d = 1'b1;
      end

      rd_data_d = rd_sel ? icnt_q : ccnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ccnt_st_q  <= StStop;
         icnt_st_q  <= StStop;
         ccnt_q     <= '0;
         icnt_q     <= '0;
         ccnt_ovf_q <= 1'b0;
         icnt_ovf_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         ccnt_st_q  <= ccnt_st_d;
         icnt_st_q  <= icnt_st_d;
         ccnt_q     <= ccnt_d;
         icnt_q     <= icnt_d;
         ccnt_ovf_q <= ccnt_ovf_d;
         icnt_ovf_q <= icnt_ovf_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign ccnt_run = (ccnt_st_q == StRun);
   assign icnt_run = (icnt_st_q == StRun);
   assign ccnt_ovf = ccnt_ovf_q;
   assign icnt_ovf = icnt_ovf_q;

endmodule

// File: tb/tb_perf_counter.sv
// Self-checking bench for perf_counter (WIDTH=8) with a behavioural model feeding
// an expected-read scoreboard.
module tb_perf_counter;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         evt_valid, str_ccnt, str_icnt, stp_cnt, inc_instr, rd_sel;
   logic [W-1:0] rd_data;
   logic         ccnt_run, icnt_run, ccnt_ovf, icnt_ovf;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] m_ccnt, m_icnt;
   logic         m_crun, m_irun, m_covf, m_iovf;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] e;

   perf_counter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .evt_valid (evt_valid),
      .str_ccnt  (str_ccnt),
      .str_icnt  (str_icnt),
      .stp_cnt   (stp_cnt),
      .inc_instr (inc_instr),
      .rd_sel    (rd_sel),
      .rd_data   (rd_data),
      .ccnt_run  (ccnt_run),
      .icnt_run  (icnt_run),
      .ccnt_ovf  (ccnt_ovf),
      .icnt_ovf  (icnt_ovf)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance the model across the edge, queue the expected read.
   task automatic drive(input logic ev, input logic sc, input logic si, input logic sp,
                        input logic inc, input logic sel);
      evt_valid = ev; str_ccnt = sc; str_icnt = si; stp_cnt = sp; inc_instr = inc;
      rd_sel = sel;
      if (!rst) begin
         exp_q.push_back('0);
         m_ccnt = '0; m_icnt = '0; m_crun = 1'b0; m_irun = 1'b0; m_covf = 1'b0; m_iovf = 1'b0;
      end else begin
         exp_q.push_back(sel ? m_icnt : m_ccnt);
         if (ev && sp) m_crun = 1'b0;
         else if (ev && sc) begin m_ccnt = '0; m_covf = 1'b0; m_crun = 1'b1; end
         else if (m_crun) begin
            if (m_ccnt == 8'hff) m_covf = 1'b1;
            m_ccnt = m_ccnt + 8'd1;
         end
         if (ev && sp) m_irun = 1'b0;
         else if (ev && si) begin m_icnt = '0; m_iovf = 1'b0; m_irun = 1'b1; end
         else if (m_irun && ev && inc) begin
            if (m_icnt == 8'hff) m_iovf = 1'b1;
            m_icnt = m_icnt + 8'd1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom));
         e = exp_q.pop_front();
         checks++;
         if (rd_data !== e) begin
            errors++; $display("FAIL reset_rd cyc%0d: got %0h exp %0h", i, rd_data, e);
         end
      end
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e || rd_data !== 8'd0) begin
         errors++; $display("FAIL reset_release_rd: got %0h exp 0", rd_data);
      end
      checks++;
      if ({ccnt_run, icnt_run, ccnt_ovf, icnt_ovf} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b exp 0000", {ccnt_run, icnt_run, ccnt_ovf, icnt_ovf});
      end
   endtask

   task automatic test_cycle_count();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      checks++;
      if (ccnt_run !== 1'b1) begin errors++; $display("FAIL ccnt_run_t1: got %b exp 1", ccnt_run); end
      // Mix stalled cycles in: the cycle counter must still advance.
      for (int i = 0; i < 9; i++) begin
         drive(1'(i % 2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (rd_data !== e || ccnt_run !== 1'b1) begin
            errors++;
            $display("FAIL ccnt_run_loop%0d: got rd=%0d run=%b exp rd=%0d run=1", i, rd_data,
                     ccnt_run, e);
         end
      end
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e || rd_data !== 8'd9 || ccnt_run !== 1'b0) begin
         errors++; $display("FAIL ccnt_stop: got rd=%0d run=%b exp rd=9 run=0", rd_data, ccnt_run);
      end
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (e !== 8'd9) begin errors++; $display("FAIL ccnt_model_hold: got %0d exp 9", e); end
      end
      checks++;
      if (rd_data !== 8'd9) begin errors++; $display("FAIL ccnt_hold: got %0d exp 9", rd_data); end
   endtask

   task automatic test_instr_count();
      logic [4:0] ev_pat;
      ev_pat = 5'b10110;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      void'(exp_q.pop_front());
      for (int i = 0; i < 5; i++) begin
         drive(ev_pat[i], 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         e = exp_q.pop_front();
         checks++;
         if (rd_data !== e || icnt_run !== 1'b1) begin
            errors++;
            $display("FAIL icnt_loop%0d: got rd=%0d run=%b exp rd=%0d run=1", i, rd_data,
                     icnt_run, e);
         end
      end
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      void'(exp_q.pop_front());
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e || rd_data !== 8'd3 || icnt_run !== 1'b0) begin
         errors++; $display("FAIL icnt_stop: got rd=%0d run=%b exp rd=3 run=0", rd_data, icnt_run);
      end
   endtask

   task automatic test_wrap();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 256; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (rd_data !== e || ccnt_ovf !== m_covf) begin
            errors++;
            $display("FAIL wrap_loop%0d: got rd=%0d ovf=%b exp rd=%0d ovf=%b", i, rd_data,
                     ccnt_ovf, e, m_covf);
         end
      end
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== 8'd0 || ccnt_ovf !== 1'b1) begin
         errors++; $display("FAIL wrap_value: got rd=%0d ovf=%b exp rd=0 ovf=1", rd_data, ccnt_ovf);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      checks++;
      if (ccnt_ovf !== 1'b0 || ccnt_run !== 1'b1) begin
         errors++;
         $display("FAIL ovf_clear: got ovf=%b run=%b exp ovf=0 run=1", ccnt_ovf, ccnt_run);
      end
   endtask

   task automatic test_stp_str_same_cycle();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 42; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         void'(exp_q.pop_front());
      end
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e || rd_data !== 8'd42 || ccnt_run !== 1'b0) begin
         errors++;
         $display("FAIL stp_str_stop: got rd=%0d run=%b exp rd=42 run=0", rd_data, ccnt_run);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== 8'd42) begin errors++; $display("FAIL stp_str_hold: got %0d exp 42", rd_data); end
   endtask

   task automatic test_reset_mid_run();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      void'(exp_q.pop_front());
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         void'(exp_q.pop_front());
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== 8'd17 || e !== 8'd17) begin
         errors++; $display("FAIL icnt_17: got %0d exp 17", rd_data);
      end
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      void'(exp_q.pop_front());
      checks++;
      if (rd_data !== 8'd0 || icnt_run !== 1'b0 || ccnt_run !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_run: got rd=%0d irun=%b crun=%b exp 0 0 0", rd_data, icnt_run,
                  ccnt_run);
      end
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      void'(exp_q.pop_front());
      checks++;
      if (rd_data !== 8'd0 || icnt_run !== 1'b0) begin
         errors++; $display("FAIL rst_after: got rd=%0d irun=%b exp 0 0", rd_data, icnt_run);
      end
   endtask

   initial begin
      rst = 1'b0; evt_valid = 1'b0; str_ccnt = 1'b0; str_icnt = 1'b0; stp_cnt = 1'b0;
      inc_instr = 1'b0; rd_sel = 1'b0;
      m_ccnt = '0; m_icnt = '0; m_crun = 1'b0; m_irun = 1'b0; m_covf = 1'b0; m_iovf = 1'b0;
      #2;
      test_reset();
      test_cycle_count();
      test_instr_count();
      test_wrap();
      test_stp_str_same_cycle();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
